// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-wide fetch queue.
// Provides the queue entry layout, the default depth and a dequeue-request clamp helper.
package fetch_pkg;

  localparam int FQ_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] instr;
  } fetch_entry_t;

  // Decode may request 0..3 entries; the queue only ever retires up to two per cycle.
  function automatic logic [1:0] clamp_deq(input logic [1:0] req);
    logic [1:0] res;
    case (req)
      2'd0:    res = 2'd0;
      2'd1:    res = 2'd1;
      2'd2:    res = 2'd2;
      2'd3:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fq_storage_2r2w.sv
// Entry storage for the fetch queue: DEPTH entries, two write ports, two
// asynchronous read ports. Contents are intentionally not reset; validity is
// tracked entirely by the pointer/count logic in the parent.
module fq_storage_2r2w
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we_0,
  input  logic [$clog2(DEPTH)-1:0] waddr_0,
  input  fetch_entry_t             wdata_0,
  input  logic                     we_1,
  input  logic [$clog2(DEPTH)-1:0] waddr_1,
  input  fetch_entry_t             wdata_1,
  input  logic [$clog2(DEPTH)-1:0] raddr_0,
  input  logic [$clog2(DEPTH)-1:0] raddr_1,
  output fetch_entry_t             rdata_0,
  output fetch_entry_t             rdata_1
);

  fetch_entry_t mem_r [DEPTH];

  // Write both slots; the parent always targets two distinct consecutive entries.
  always_ff @(posedge clk) begin
    if (we_0) begin
      mem_r[waddr_0] <= wdata_0;
    end
    if (we_1) begin
      mem_r[waddr_1] <= wdata_1;
    end
  end

  assign rdata_0 = mem_r[raddr_0];
  assign rdata_1 = mem_r[raddr_1];

endmodule

// File: rtl/fetch_queue_2w.sv
// Two-wide fetch queue between the I-cache and decode.
// Accepts up to two instructions per cycle (slot 0 older than slot 1) and
// presents the two oldest entries to decode, which retires 0..2 per cycle.
// Optional feature: define FETCHQ_STATS_EN to build the saturating
// enqueue-stall cycle counter on stall_cycles_o; otherwise it reads 0.
module fetch_queue_2w
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_0_i,
  input  logic             in_valid_1_i,
  input  logic [63:0]      in_pc_0_i,
  input  logic [63:0]      in_pc_1_i,
  input  logic [63:0]      in_data_0_i,
  input  logic [63:0]      in_data_1_i,
  output logic             in_ready_o,
  output logic             out_valid_0_o,
  output logic             out_valid_1_o,
  output logic [63:0]      out_pc_0_o,
  output logic [63:0]      out_pc_1_o,
  output logic [63:0]      out_data_0_o,
  output logic [63:0]      out_data_1_o,
  input  logic [1:0]       deq_cnt_i,
  output logic [CNT_W-1:0] count_o,
  output logic [31:0]      stall_cycles_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] head_next_s;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] tail_next_s;
  logic             ready_r;
  logic             valid_0_r;
  logic             valid_1_r;

  logic             enq_0_s;
  logic             enq_1_s;
  logic [1:0]       enq_n_s;
  logic [1:0]       deq_req_s;
  logic [1:0]       deq_eff_s;

  fetch_entry_t     wdata_0_s;
  fetch_entry_t     wdata_1_s;
  fetch_entry_t     rdata_0_s;
  fetch_entry_t     rdata_1_s;

  assign wdata_0_s = '{pc: in_pc_0_i, instr: in_data_0_i};
  assign wdata_1_s = '{pc: in_pc_1_i, instr: in_data_1_i};

  // Decide how many entries move in and out this cycle.
  always_comb begin
    enq_0_s   = 1'b0;
    enq_1_s   = 1'b0;
    enq_n_s   = 2'd0;
    deq_req_s = clamp_deq(deq_cnt_i);
    deq_eff_s = 2'd0;
    // Ready comes from registered occupancy, so a full queue drops the request outright.
    if (in_valid_0_i && ready_r) begin
      enq_0_s = 1'b1;
      enq_1_s = in_valid_1_i;
    end else begin
      enq_0_s = 1'b0;
      enq_1_s = 1'b0;
    end
    enq_n_s = {1'b0, enq_0_s} + {1'b0, enq_1_s};
    // Never retire more entries than are present.
    if ({{(CNT_W-2){1'b0}}, deq_req_s} > count_r) begin
      deq_eff_s = count_r[1:0];
    end else begin
      deq_eff_s = deq_req_s;
    end
  end

  // Next pointers and occupancy; flush wins over any same-cycle traffic.
  always_comb begin
    count_next_s = count_r;
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    if (flush_i) begin
      count_next_s = '0;
      head_next_s  = '0;
      tail_next_s  = '0;
    end else begin
      count_next_s = count_r + CNT_W'(enq_n_s) - CNT_W'(deq_eff_s);
      head_next_s  = head_r + PTR_W'(deq_eff_s);
      tail_next_s  = tail_r + PTR_W'(enq_n_s);
    end
  end

  // Queue state plus registered status flags derived from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      ready_r   <= 1'b1;
      valid_0_r <= 1'b0;
      valid_1_r <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      head_r    <= head_next_s;
      tail_r    <= tail_next_s;
      ready_r   <= (DEPTH_C - count_next_s) >= TWO_C;
      valid_0_r <= count_next_s >= CNT_W'(1);
      valid_1_r <= count_next_s >= TWO_C;
    end
  end

  fq_storage_2r2w #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .we_0    (enq_0_s & ~flush_i),
    .waddr_0 (tail_r),
    .wdata_0 (wdata_0_s),
    .we_1    (enq_1_s & ~flush_i),
    .waddr_1 (tail_r + PTR_W'(1)),
    .wdata_1 (wdata_1_s),
    .raddr_0 (head_r),
    .raddr_1 (head_r + PTR_W'(1)),
    .rdata_0 (rdata_0_s),
    .rdata_1 (rdata_1_s)
  );

  assign in_ready_o    = ready_r;
  assign out_valid_0_o = valid_0_r;
  assign out_valid_1_o = valid_1_r;
  assign count_o       = count_r;
  assign out_pc_0_o    = rdata_0_s.pc;
  assign out_data_0_o  = rdata_0_s.instr;
  assign out_pc_1_o    = rdata_1_s.pc;
  assign out_data_1_o  = rdata_1_s.instr;

`ifdef FETCHQ_STATS_EN
  logic [31:0] stall_r;

  // Count cycles where the I-cache offered work but the queue could not take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= 32'd0;
    end else if (in_valid_0_i && !ready_r && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cycles_o = stall_r;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule
